// File: rtl/pipe_stage_skid.sv
// rtl/pipe_stage_skid.sv - pipeline stage register with valid/ready handshake and 2-entry skid buffer
module pipe_stage_skid #(
    parameter int CTRL_W    = 3,
    parameter int DATA_W    = 69,
    parameter int ZERO_DATA = 1
) (
    input  logic              clk,
    input  logic              startin,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [CTRL_W-1:0] head_ctrl, skid_ctrl;
    logic [DATA_W-1:0] head_data, skid_data;
    logic              head_valid, skid_valid;
    logic              push, pop;
    logic              ld_head_in, ld_skid_in, ld_head_skid;

    assign head_valid = (state == ONE) || (state == FULL);
    assign skid_valid = (state == FULL);

    // in_ready depends on registered state only, never on out_ready
    assign in_ready  = !skid_valid;
    assign out_valid = head_valid;
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    assign occupancy = {1'b0, head_valid} + {1'b0, skid_valid};

    always_comb begin
        state_nxt    = state;
        ld_head_in   = 1'b0;
        ld_skid_in   = 1'b0;
        ld_head_skid = 1'b0;
        if (flush) begin
            state_nxt = EMPTY;
        end else begin
            case (state)
                EMPTY: begin
                    if (push) begin
                        ld_head_in = 1'b1;
                        state_nxt  = ONE;
                    end
                end
                ONE: begin
                    if (push && pop) begin
                        ld_head_in = 1'b1;
                    end else if (push) begin
                        ld_skid_in = 1'b1;
                        state_nxt  = FULL;
                    end else if (pop) begin
                        state_nxt = EMPTY;
                    end
                end
                FULL: begin
                    if (pop) begin
                        ld_head_skid = 1'b1;
                        state_nxt    = ONE;
                    end
                end
                default: state_nxt = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (startin) begin
            state     <= EMPTY;
            head_ctrl <= '0;
            head_data <= '0;
            skid_ctrl <= '0;
            skid_data <= '0;
        end else begin
            state <= state_nxt;
            if (ld_head_in) begin
                head_ctrl <= in_ctrl;
                head_data <= in_data;
            end else if (ld_head_skid) begin
                head_ctrl <= skid_ctrl;
                head_data <= skid_data;
            end
            if (ld_skid_in) begin
                skid_ctrl <= in_ctrl;
                skid_data <= in_data;
            end
        end
    end

    // bubbles never carry control bits
    assign out_ctrl = head_valid ? head_ctrl : '0;

    generate
        if (ZERO_DATA != 0) begin : g_zero_data
            assign out_data = head_valid ? head_data : '0;
        end else begin : g_raw_data
            assign out_data = head_data;
        end
    endgenerate

endmodule
